// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM8 arbiter slice.
package mem_arb_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef logic port_id_t;

endpackage

// File: rtl/rr_pick.sv
// Two-way combinational picker: one-hot grant from the eligible request vector.
// Build option: ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins) instead of round-robin.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] elig,
    input  port_id_t   last,
    output logic [1:0] gnt,
    output logic       valid
);

`ifdef ARB_FIXED_PRIO_EN
    // Port 0 always wins contention; last is ignored in this variant.
    always_comb begin
        gnt   = '0;
        valid = |elig;
        if (elig[0]) begin
            gnt = 2'b01;
        end else if (elig[1]) begin
            gnt = 2'b10;
        end
    end
`else
    // On contention grant the port that was not served last.
    always_comb begin
        gnt   = elig;
        valid = |elig;
        if (elig == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end
`endif

endmodule

// File: rtl/ram8_arbiter.sv
// Two-port arbiter/sequencer sharing one RAM8 (8 x 16) with registered RAM pins.
// Build option: ARB_FIXED_PRIO_EN switches the picker to fixed port-0 priority.
module ram8_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = mem_arb_pkg::DATA_W,
    parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              re,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_e,
    output logic              ram_w,
    output logic              ram_r,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_t            state_q, state_d;
    port_id_t          sel_q, last_q;
    logic [1:0]        elig, pick_gnt;
    logic              pick_valid;
    port_id_t          pick_port;
    logic              ram_w_d, ram_r_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_din_d;
    logic              rd_done0, rd_done1;

    rr_pick u_pick (
        .elig  (elig),
        .last  (last_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // Next-state and next RAM-pin values; the port served now is masked from the next pick.
    always_comb begin
        elig       = {req1, req0};
        state_d    = IDLE;
        pick_port  = pick_gnt[1];
        ram_w_d    = 1'b0;
        ram_r_d    = 1'b0;
        ram_addr_d = ram_addr;
        ram_din_d  = ram_din;
        if (state_q == ACCESS) begin
            elig = {req1 & (sel_q != 1'b1), req0 & (sel_q != 1'b0)};
        end
        if (pick_valid) begin
            state_d    = ACCESS;
            ram_addr_d = pick_port ? addr1 : addr0;
            ram_din_d  = pick_port ? wdata1 : wdata0;
            ram_w_d    = pick_port ? we1 : we0;
            ram_r_d    = ~ram_w_d;
        end
        rd_done0 = (state_q == ACCESS) && ram_r && (sel_q == 1'b0);
        rd_done1 = (state_q == ACCESS) && ram_r && (sel_q == 1'b1);
    end

    // State, registered RAM pins, grants and read-data capture.
    always_ff @(posedge clk or negedge re) begin
        if (!re) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            ram_e    <= 1'b0;
            ram_w    <= 1'b0;
            ram_r    <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            state_q  <= state_d;
            gnt0     <= pick_gnt[0];
            gnt1     <= pick_gnt[1];
            ram_e    <= pick_valid;
            ram_w    <= ram_w_d;
            ram_r    <= ram_r_d;
            ram_addr <= ram_addr_d;
            ram_din  <= ram_din_d;
            if (pick_valid) begin
                sel_q  <= pick_port;
                last_q <= pick_port;
            end
            rvalid0 <= rd_done0;
            rvalid1 <= rd_done1;
            if (rd_done0) begin
                rdata0 <= ram_dout;
            end
            if (rd_done1) begin
                rdata1 <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed table-driven bench for ram8_arbiter with a behavioural RAM8 model.
module tb_ram8_arbiter;

    logic        clk = 1'b0;
    logic        re;
    logic        req0, req1, we0, we1;
    logic [2:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic        ram_e, ram_w, ram_r;
    logic [2:0]  ram_addr;
    logic [15:0] ram_din, ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    // RAM8: combinational read, write captured at the rising edge.
    logic [15:0] mem [8] = '{16'h0000, 16'h0011, 16'h0022, 16'h0000,
                             16'h0000, 16'h1234, 16'h0000, 16'h0000};
    assign ram_dout = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_e && ram_w) mem[ram_addr] <= ram_din;
    end

    always #5 clk = ~clk;

    ram8_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .re(re),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_e(ram_e), .ram_w(ram_w), .ram_r(ram_r),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    typedef struct packed {
        logic r0; logic w0; logic [2:0] a0; logic [15:0] d0;
        logic r1; logic w1; logic [2:0] a1; logic [15:0] d1;
        logic g0; logic g1; logic e; logic w; logic r;
        logic [2:0] addr; logic [15:0] din;
        logic rv0; logic rv1; logic [15:0] rd0; logic [15:0] rd1;
    } vec_t;

    vec_t tbl [27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [2:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [2:0] a1, input logic [15:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    initial begin
        // r0 w0 a0 d0 | r1 w1 a1 d1 || g0 g1 e w r addr din rv0 rv1 rd0 rd1
        // Contention from IDLE: port 0 first, port 1 next cycle.
        tbl[0]  = '{1'b1,1'b0,3'd1,16'h0, 1'b1,1'b0,3'd2,16'h0, 1'b1,1'b0,1'b1,1'b0,1'b1,3'd1,16'h0, 1'b0,1'b0,16'h0000,16'h0000};
        tbl[1]  = '{1'b0,1'b0,3'd0,16'h0, 1'b1,1'b0,3'd2,16'h0, 1'b0,1'b1,1'b1,1'b0,1'b1,3'd2,16'h0, 1'b1,1'b0,16'h0011,16'h0000};
        tbl[2]  = '{1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,3'd2,16'h0, 1'b0,1'b1,16'h0011,16'h0022};
        // Port 0 write A5A5 to addr 3, then read it back.
        tbl[3]  = '{1'b1,1'b1,3'd3,16'hA5A5, 1'b0,1'b0,3'd0,16'h0, 1'b1,1'b0,1'b1,1'b1,1'b0,3'd3,16'hA5A5, 1'b0,1'b0,16'h0011,16'h0022};
        tbl[4]  = '{1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,3'd3,16'hA5A5, 1'b0,1'b0,16'h0011,16'h0022};
        tbl[5]  = '{1'b1,1'b0,3'd3,16'h0, 1'b0,1'b0,3'd0,16'h0, 1'b1,1'b0,1'b1,1'b0,1'b1,3'd3,16'h0, 1'b0,1'b0,16'h0011,16'h0022};
        tbl[6]  = '{1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,3'd3,16'h0, 1'b1,1'b0,16'hA5A5,16'h0022};
        // Isolated port-1 read of addr 1 (leaves last = 1).
        tbl[7]  = '{1'b0,1'b0,3'd0,16'h0, 1'b1,1'b0,3'd1,16'h0, 1'b0,1'b1,1'b1,1'b0,1'b1,3'd1,16'h0, 1'b0,1'b0,16'hA5A5,16'h0022};
        tbl[8]  = '{1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,3'd1,16'h0, 1'b0,1'b1,16'hA5A5,16'h0011};
        // Fairness: both held 8 cycles, strict alternation starting at port 0.
        tbl[9]  = '{1'b1,1'b0,3'd1,16'h0, 1'b1,1'b0,3'd2,16'h0, 1'b1,1'b0,1'b1,1'b0,1'b1,3'd1,16'h0, 1'b0,1'b0,16'hA5A5,16'h0011};
        tbl[10] = '{1'b1,1'b0,3'd1,16'h0, 1'b1,1'b0,3'd2,16'h0, 1'b0,1'b1,1'b1,1'b0,1'b1,3'd2,16'h0, 1'b1,1'b0,16'h0011,16'h0011};
        tbl[11] = '{1'b1,1'b0,3'd1,16'h0, 1'b1,1'b0,3'd2,16'h0, 1'b1,1'b0,1'b1,1'b0,1'b1,3'd1,16'h0, 1'b0,1'b1,16'h0011,16'h0022};
        tbl[12] = '{1'b1,1'b0,3'd1,16'h0, 1'b1,1'b0,3'd2,16'h0, 1'b0,1'b1,1'b1,1'b0,1'b1,3'd2,16'h0, 1'b1,1'b0,16'h0011,16'h0022};
        tbl[13] = '{1'b1,1'b0,3'd1,16'h0, 1'b1,1'b0,3'd2,16'h0, 1'b1,1'b0,1'b1,1'b0,1'b1,3'd1,16'h0, 1'b0,1'b1,16'h0011,16'h0022};
        tbl[14] = '{1'b1,1'b0,3'd1,16'h0, 1'b1,1'b0,3'd2,16'h0, 1'b0,1'b1,1'b1,1'b0,1'b1,3'd2,16'h0, 1'b1,1'b0,16'h0011,16'h0022};
        tbl[15] = '{1'b1,1'b0,3'd1,16'h0, 1'b1,1'b0,3'd2,16'h0, 1'b1,1'b0,1'b1,1'b0,1'b1,3'd1,16'h0, 1'b0,1'b1,16'h0011,16'h0022};
        tbl[16] = '{1'b1,1'b0,3'd1,16'h0, 1'b1,1'b0,3'd2,16'h0, 1'b0,1'b1,1'b1,1'b0,1'b1,3'd2,16'h0, 1'b1,1'b0,16'h0011,16'h0022};
        tbl[17] = '{1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,3'd2,16'h0, 1'b0,1'b1,16'h0011,16'h0022};
        // Single port streaming: req0 held 6 cycles, grants every other cycle.
        tbl[18] = '{1'b1,1'b0,3'd3,16'h0, 1'b0,1'b0,3'd0,16'h0, 1'b1,1'b0,1'b1,1'b0,1'b1,3'd3,16'h0, 1'b0,1'b0,16'h0011,16'h0022};
        tbl[19] = '{1'b1,1'b0,3'd3,16'h0, 1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,3'd3,16'h0, 1'b1,1'b0,16'hA5A5,16'h0022};
        tbl[20] = '{1'b1,1'b0,3'd3,16'h0, 1'b0,1'b0,3'd0,16'h0, 1'b1,1'b0,1'b1,1'b0,1'b1,3'd3,16'h0, 1'b0,1'b0,16'hA5A5,16'h0022};
        tbl[21] = '{1'b1,1'b0,3'd3,16'h0, 1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,3'd3,16'h0, 1'b1,1'b0,16'hA5A5,16'h0022};
        tbl[22] = '{1'b1,1'b0,3'd3,16'h0, 1'b0,1'b0,3'd0,16'h0, 1'b1,1'b0,1'b1,1'b0,1'b1,3'd3,16'h0, 1'b0,1'b0,16'hA5A5,16'h0022};
        tbl[23] = '{1'b1,1'b0,3'd3,16'h0, 1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,3'd3,16'h0, 1'b1,1'b0,16'hA5A5,16'h0022};
        tbl[24] = '{1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,3'd3,16'h0, 1'b0,1'b0,16'hA5A5,16'h0022};
        // Isolated req1 granted immediately.
        tbl[25] = '{1'b0,1'b0,3'd0,16'h0, 1'b1,1'b0,3'd5,16'h0, 1'b0,1'b1,1'b1,1'b0,1'b1,3'd5,16'h0, 1'b0,1'b0,16'hA5A5,16'h0022};
        tbl[26] = '{1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,3'd0,16'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,3'd5,16'h0, 1'b0,1'b1,16'hA5A5,16'h1234};

        re = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
        #12;
        check("rst gnt0", {31'b0, gnt0}, 32'd0);
        check("rst gnt1", {31'b0, gnt1}, 32'd0);
        check("rst ram_e", {31'b0, ram_e}, 32'd0);
        check("rst ram_addr", {29'b0, ram_addr}, 32'd0);
        check("rst rdata0", {16'b0, rdata0}, 32'd0);
        #10 re = 1'b1;

        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            @(posedge clk);
            #1;
            check($sformatf("row%0d gnt0", i), {31'b0, gnt0}, {31'b0, tbl[i].g0});
            check($sformatf("row%0d gnt1", i), {31'b0, gnt1}, {31'b0, tbl[i].g1});
            check($sformatf("row%0d ram_e", i), {31'b0, ram_e}, {31'b0, tbl[i].e});
            check($sformatf("row%0d ram_w", i), {31'b0, ram_w}, {31'b0, tbl[i].w});
            check($sformatf("row%0d ram_r", i), {31'b0, ram_r}, {31'b0, tbl[i].r});
            check($sformatf("row%0d ram_addr", i), {29'b0, ram_addr}, {29'b0, tbl[i].addr});
            check($sformatf("row%0d ram_din", i), {16'b0, ram_din}, {16'b0, tbl[i].din});
            check($sformatf("row%0d rvalid0", i), {31'b0, rvalid0}, {31'b0, tbl[i].rv0});
            check($sformatf("row%0d rvalid1", i), {31'b0, rvalid1}, {31'b0, tbl[i].rv1});
            check($sformatf("row%0d rdata0", i), {16'b0, rdata0}, {16'b0, tbl[i].rd0});
            check($sformatf("row%0d rdata1", i), {16'b0, rdata1}, {16'b0, tbl[i].rd1});
        end

        // Reset mid-write: FFFF to addr 5 must not commit.
        drive(1'b1, 1'b1, 3'd5, 16'hFFFF, 1'b0, 1'b0, 3'd0, 16'h0);
        @(posedge clk);
        #1;
        check("mw gnt0", {31'b0, gnt0}, 32'd1);
        check("mw ram_w", {31'b0, ram_w}, 32'd1);
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
        #2 re = 1'b0;
        #1;
        check("mw rst gnt0", {31'b0, gnt0}, 32'd0);
        check("mw rst ram_w", {31'b0, ram_w}, 32'd0);
        check("mw rst ram_e", {31'b0, ram_e}, 32'd0);
        check("mw rst ram_addr", {29'b0, ram_addr}, 32'd0);
        check("mw rst ram_din", {16'b0, ram_din}, 32'd0);
        check("mw rst rdata0", {16'b0, rdata0}, 32'd0);
        check("mw rst rdata1", {16'b0, rdata1}, 32'd0);
        @(posedge clk);
        #3 re = 1'b1;
        check("mw mem5", {16'b0, mem[5]}, 32'h1234);
        drive(1'b1, 1'b0, 3'd5, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
        @(posedge clk);
        #1;
        check("mw rvalid0 none", {31'b0, rvalid0}, 32'd0);
        check("mw rd gnt0", {31'b0, gnt0}, 32'd1);
        check("mw rd ram_addr", {29'b0, ram_addr}, 32'd5);
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
        @(posedge clk);
        #1;
        check("mw rd rvalid0", {31'b0, rvalid0}, 32'd1);
        check("mw rd rdata0", {16'b0, rdata0}, 32'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
